controlador_contador_gray: RTL

Sequencer and checker for the 5-bit Gray counter: on request, clears the counter, enables it for a programmed number of increments, and compares its Gray output every cycle against an internal binary shadow count converted to Gray. It drives the counter's active-low reset and enable pins, replacing the stimulus the probador generates by hand, and reports done, busy and mismatch status to the bench or a higher-level controller.

---
 rtl/controlador_contador_gray.sv | 95 +++++++++
 1 files changed

// File: rtl/controlador_contador_gray.sv
// Sequencer and checker for a Gray counter: clears it, enables it for a programmed number of
// increments and compares its Gray output every cycle against a binary shadow count.
module controlador_contador_gray #(
    parameter int unsigned ANCHO     = 5,
    parameter int unsigned ANCHO_N   = 6,
    parameter int unsigned ANCHO_ERR = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inicio,
    input  logic [ANCHO_N-1:0]   num_cuentas,
    input  logic                 pausa,
    input  logic [ANCHO-1:0]     salida_gray,
    output logic                 reset_L_contador,
    output logic                 enable_contador,
    output logic                 ocupado,
    output logic                 listo,
    output logic                 error,
    output logic [ANCHO_ERR-1:0] errores,
    output logic [ANCHO-1:0]     esperado_gray
);

    typedef enum logic [1:0] {StIdle, StLimpiar, StContar, StFin} estado_t;

    estado_t                estado_q;
    logic [ANCHO_N-1:0]     restantes_q;
    logic [ANCHO-1:0]       cuenta_q;
    logic                   error_q;
    logic [ANCHO_ERR-1:0]   errores_q;
    logic                   comparar;
    logic                   discrepancia;

    assign esperado_gray = cuenta_q ^ (cuenta_q >> 1);
    assign comparar      = (estado_q == StContar) || (estado_q == StFin);
    assign discrepancia  = comparar && (salida_gray != esperado_gray);

    always_comb begin
        reset_L_contador = (estado_q != StLimpiar);
        ocupado          = (estado_q != StIdle);
        listo            = (estado_q == StFin);
        // Only output with a combinational input path: pausa must stop the counter that cycle.
        enable_contador  = (estado_q == StContar) && !pausa;
        error            = error_q;
        errores          = errores_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q    <= StIdle;
            restantes_q <= '0;
            cuenta_q    <= '0;
            error_q     <= 1'b0;
            errores_q   <= '0;
        end else begin
            unique case (estado_q)
                StIdle: begin
                    if (inicio) begin
                        restantes_q <= num_cuentas;
                        cuenta_q    <= '0;
                        error_q     <= 1'b0;
                        errores_q   <= '0;
                        estado_q    <= StLimpiar;
                    end
                end
                StLimpiar: begin
                    estado_q <= (restantes_q == '0) ? StFin : StContar;
                end
                StContar: begin
                    if (!pausa) begin
                        cuenta_q    <= cuenta_q + ANCHO'(1);
                        restantes_q <= restantes_q - ANCHO_N'(1);
                        if (restantes_q == ANCHO_N'(1)) begin
                            estado_q <= StFin;
                        end
                    end
                end
                StFin: begin
                    estado_q <= StIdle;
                end
                default: begin
                    estado_q <= StIdle;
                end
            endcase

            // Compares only happen in CONTAR/FIN, so this never collides with the IDLE clear.
            if (discrepancia) begin
                error_q <= 1'b1;
                if (errores_q != '1) begin
                    errores_q <= errores_q + ANCHO_ERR'(1);
                end
            end
        end
    end

endmodule
